// File: rtl/rtc_alarm_pkg.sv
// Shared types, limits and BCD helpers for the RTC alarm core.
package rtc_alarm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RINGING  = 2'd1,
    SNOOZING = 2'd2
  } alarm_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int SEC_MAX    = 59;
  localparam int MIN_MAX    = 59;
  localparam int HOUR24_MAX = 23;
  localparam int HOUR12_MAX = 12;

  // Two-digit BCD encoding of a small constant (0..99).
  function automatic logic [7:0] to_bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Increment a two-digit BCD value; the caller handles wrap limits.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // A time/alarm load is accepted only if every digit is decimal, minutes
  // are below 60 and hours fall in the range of the selected mode.
  function automatic logic load_valid(input logic [7:0] hh, input logic [7:0] mm,
                                      input bit mode_12h);
    int hv;
    hv = 10 * int'(hh[7:4]) + int'(hh[3:0]);
    if (hh[7:4] > 4'd9 || hh[3:0] > 4'd9 || mm[3:0] > 4'd9 ||
        mm[7:4] > 4'(MIN_MAX / 10)) return 1'b0;
    if (mode_12h) return (hv >= 1) && (hv <= HOUR12_MAX);
    return hv <= HOUR24_MAX;
  endfunction

endpackage

// File: rtl/rtc_alarm_core_bcd_digit_counter.sv
// One BCD digit with enable, load, programmable wrap value and carry out.
module bcd_digit_counter
  import rtc_alarm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  bcd_digit_t max_val,
  output bcd_digit_t digit,
  output bcd_digit_t digit_nxt,
  output logic       carry
);

  // Next digit value: load wins over counting; wrap to zero past max_val.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    digit_nxt = digit;
    carry     = en && !load && (digit == max_val);
    if (load)       digit_nxt = load_val;
    else if (carry) digit_nxt = 4'd0;
    else if (en)    digit_nxt = digit + 4'd1;
  end

  // Digit register.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) digit <= 4'd0;
    else       digit <= digit_nxt;
  end

endmodule

// File: rtl/rtc_alarm_core.sv
// BCD time-of-day core with alarm, bounded ringing and optional snooze.
// Optional feature macro: ALARM_SNOOZE_EN (snooze state and counter).
module rtc_alarm_core
  import rtc_alarm_pkg::*;
#(
  parameter bit MODE_12H   = 1'b0,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       run,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic       set_pm,
  input  logic       alarm_arm,
  input  logic       alarm_off,
  input  logic       snooze,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic       pm,
  output logic       alarm_out,
  output logic       day_carry,
  output logic       set_err
);

  localparam logic [7:0] HH_RESET  = MODE_12H ? to_bcd8(HOUR12_MAX) : 8'h00;
  localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);

  logic       load_ok, do_time, do_alarm, adv;
  logic       ss_u_c, ss_c, mm_u_c, hr_en, match;
  logic [7:0] mm_nxt, unused_ss_nxt;
  logic [7:0] hh_q, hh_nxt, al_hh, al_mm;
  logic       pm_q, pm_nxt, al_pm, day_nxt;

  alarm_state_t state, state_nxt;
  logic [7:0]   ring_cnt, ring_cnt_nxt;

  assign load_ok  = load_valid(set_hh, set_mm, MODE_12H);
  assign do_time  = set_time && load_ok;
  assign do_alarm = set_alarm && load_ok;
  // Any set_time pulse swallows a coincident tick.
  assign adv      = tick && run && !set_time;

  bcd_digit_counter u_ss_u (.clk, .reset, .en(adv), .load(set_time && load_ok),
    .load_val(4'd0), .max_val(4'd9), .digit(ss_bcd[3:0]),
    .digit_nxt(unused_ss_nxt[3:0]), .carry(ss_u_c));
  bcd_digit_counter u_ss_t (.clk, .reset, .en(ss_u_c), .load(do_time),
    .load_val(4'd0), .max_val(4'(SEC_MAX / 10)), .digit(ss_bcd[7:4]),
    .digit_nxt(unused_ss_nxt[7:4]), .carry(ss_c));
  bcd_digit_counter u_mm_u (.clk, .reset, .en(ss_c), .load(do_time),
    .load_val(set_mm[3:0]), .max_val(4'd9), .digit(mm_bcd[3:0]),
    .digit_nxt(mm_nxt[3:0]), .carry(mm_u_c));
  bcd_digit_counter u_mm_t (.clk, .reset, .en(mm_u_c), .load(do_time),
    .load_val(set_mm[7:4]), .max_val(4'(MIN_MAX / 10)), .digit(mm_bcd[7:4]),
    .digit_nxt(mm_nxt[7:4]), .carry(hr_en));

  // Hours and AM/PM: load, or advance on minute carry with mode-specific wrap.
  always_comb begin
    hh_nxt  = hh_q;
    pm_nxt  = pm_q;
    day_nxt = 1'b0;
    if (do_time) begin
      hh_nxt = set_hh;
      pm_nxt = MODE_12H ? set_pm : 1'b0;
    end else if (hr_en) begin
      if (!MODE_12H) begin
        if (hh_q == to_bcd8(HOUR24_MAX)) begin
          hh_nxt  = 8'h00;
          day_nxt = 1'b1;
        end else begin
          hh_nxt = bcd_inc(hh_q);
        end
      end else if (hh_q == to_bcd8(HOUR12_MAX)) begin
        hh_nxt = 8'h01;
      end else begin
        hh_nxt = bcd_inc(hh_q);
        if (hh_q == to_bcd8(HOUR12_MAX - 1)) begin
          pm_nxt  = !pm_q;
          day_nxt = pm_q;
        end
      end
    end
  end

  // A match only exists when a tick rolls the seconds over to 00.
  assign match = adv && ss_c && alarm_arm && (hh_nxt == al_hh) &&
                 (mm_nxt == al_mm) && (pm_nxt == al_pm);

`ifdef ALARM_SNOOZE_EN
  localparam logic [11:0] SNZ_LOAD = 12'(SNOOZE_MIN * 60);
  logic [11:0] snz_cnt, snz_cnt_nxt;
`else
  localparam int unused_snooze_min = SNOOZE_MIN;
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  // Alarm FSM: cancel requests first, then snooze, then tick-driven timeouts.
  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_nxt  = snz_cnt;
`endif
    case (state)
      IDLE: if (match) begin
        state_nxt    = RINGING;
        ring_cnt_nxt = 8'd0;
      end
      RINGING: begin
        if (alarm_off || !alarm_arm || do_alarm) state_nxt = IDLE;
`ifdef ALARM_SNOOZE_EN
        else if (snooze) begin
          state_nxt   = SNOOZING;
          snz_cnt_nxt = SNZ_LOAD;
        end
`endif
        else if (tick) begin
          if (ring_cnt == RING_LAST) state_nxt = IDLE;
          else                       ring_cnt_nxt = ring_cnt + 8'd1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZING: begin
        if (alarm_off || !alarm_arm || do_alarm) state_nxt = IDLE;
        else if (tick) begin
          if (snz_cnt == 12'd1) begin
            state_nxt    = RINGING;
            ring_cnt_nxt = 8'd0;
          end else begin
            snz_cnt_nxt = snz_cnt - 12'd1;
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Time, alarm setting, FSM and pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      hh_q      <= HH_RESET;
      pm_q      <= 1'b0;
      al_hh     <= HH_RESET;
      al_mm     <= 8'h00;
      al_pm     <= 1'b0;
      state     <= IDLE;
      ring_cnt  <= 8'd0;
      alarm_out <= 1'b0;
      day_carry <= 1'b0;
      set_err   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt   <= 12'd0;
`endif
    end else begin
      hh_q      <= hh_nxt;
      pm_q      <= pm_nxt;
      if (do_alarm) begin
        al_hh <= set_hh;
        al_mm <= set_mm;
        al_pm <= MODE_12H ? set_pm : 1'b0;
      end
      state     <= state_nxt;
      ring_cnt  <= ring_cnt_nxt;
      alarm_out <= (state_nxt == RINGING);
      day_carry <= day_nxt;
      set_err   <= (set_time || set_alarm) && !load_ok;
`ifdef ALARM_SNOOZE_EN
      snz_cnt   <= snz_cnt_nxt;
`endif
    end
  end

  assign hh_bcd = hh_q;
  assign pm     = pm_q;

endmodule
